// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, bus word types and the arbiter
// grant state encoding.
package wb_pkg;

    localparam int WB_ADDR_WIDTH          = 2;
    localparam int WB_DATA_WIDTH          = 8;
    localparam int WB_ARB_TIMEOUT_DEFAULT = 16;

    typedef logic [WB_ADDR_WIDTH-1:0] wb_addr;
    typedef logic [WB_DATA_WIDTH-1:0] wb_data;

    // Grant state; the encoding doubles as the one-hot owner vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } wb_gnt_t;

    // One-hot owner vector for a grant state (00 = no owner).
    function automatic logic [1:0] gnt_onehot(input wb_gnt_t st);
        logic [1:0] oh;
        case (st)
            GNT0:    oh = 2'b01;
            GNT1:    oh = 2'b10;
            default: oh = 2'b00;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/wb_ack_watchdog.sv
// Ack watchdog: counts strobe cycles without an ack and flags a timeout in
// the cycle the count reaches the limit. A limit of 0 disables it.
module wb_ack_watchdog
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = WB_ARB_TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic stb_i,
    input  logic ack_i,
    input  logic clr_i,
    output logic timeout_o
);

    localparam int             CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic             ENABLE = (TIMEOUT_CYCLES > 0);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             timeout_s;

    // Timeout detection and saturating next-count; an ack on the threshold
    // cycle suppresses the timeout.
    always_comb begin
        timeout_s    = 1'b0;
        count_next_s = count_r;
        if (ENABLE && (count_r == LIMIT) && stb_i && !ack_i) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
        if (clr_i || ack_i || !stb_i || timeout_s) begin
            count_next_s = '0;
        end else if (count_r != LIMIT) begin
            count_next_s = count_r + CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_r <= '0;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign timeout_o = timeout_s;

endmodule

// File: rtl/wb_arbiter.sv
// Two-master / one-slave Wishbone arbiter: round-robin grant held for the
// whole cyc burst, combinational mux from the registered grant, and an ack
// watchdog that ends a hung transfer with an err pulse to the owner.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = WB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = WB_ARB_TIMEOUT_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    output logic [1:0]            gnt_o
);

    wb_gnt_t state_r;
    wb_gnt_t state_next_s;
    logic    last_owner_r;
    logic    last_owner_next_s;
    logic    stb_raw_s;
    logic    timeout_s;
    logic    gnt_change_s;

    // Next grant: round-robin on ties from IDLE, direct handover when the
    // owner releases cyc while the other master is already waiting.
    always_comb begin
        state_next_s      = state_r;
        last_owner_next_s = last_owner_r;
        case (state_r)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_next_s = last_owner_r ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_next_s = GNT0;
                end else if (m1_cyc_i) begin
                    state_next_s = GNT1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    last_owner_next_s = 1'b0;
                    state_next_s      = m1_cyc_i ? GNT1 : IDLE;
                end else begin
                    state_next_s = GNT0;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    last_owner_next_s = 1'b1;
                    state_next_s      = m0_cyc_i ? GNT0 : IDLE;
                end else begin
                    state_next_s = GNT1;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Grant and round-robin history registers; master 0 wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            last_owner_r <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            last_owner_r <= last_owner_next_s;
        end
    end

    // Slave-side mux from the registered grant; a timeout masks the strobe.
    always_comb begin
        s_cyc_o   = 1'b0;
        stb_raw_s = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = {ADDR_WIDTH{1'b0}};
        s_dat_o   = {DATA_WIDTH{1'b0}};
        case (state_r)
            GNT0: begin
                s_cyc_o   = m0_cyc_i;
                stb_raw_s = m0_stb_i;
                s_we_o    = m0_we_i;
                s_adr_o   = m0_adr_i;
                s_dat_o   = m0_dat_i;
            end
            GNT1: begin
                s_cyc_o   = m1_cyc_i;
                stb_raw_s = m1_stb_i;
                s_we_o    = m1_we_i;
                s_adr_o   = m1_adr_i;
                s_dat_o   = m1_dat_i;
            end
            default: begin
                s_cyc_o   = 1'b0;
                stb_raw_s = 1'b0;
            end
        endcase
        s_stb_o = stb_raw_s & ~timeout_s;
    end

    assign gnt_change_s = (state_next_s != state_r);

    wb_ack_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .stb_i    (stb_raw_s),
        .ack_i    (s_ack_i),
        .clr_i    (gnt_change_s),
        .timeout_o(timeout_s)
    );

    // Return path: only the current owner sees ack, err and read data.
    assign gnt_o    = gnt_onehot(state_r);
    assign m0_ack_o = s_ack_i & gnt_o[0];
    assign m1_ack_o = s_ack_i & gnt_o[1];
    assign m0_err_o = timeout_s & gnt_o[0];
    assign m1_err_o = timeout_s & gnt_o[1];
    assign m0_dat_o = gnt_o[0] ? s_dat_i : {DATA_WIDTH{1'b0}};
    assign m1_dat_o = gnt_o[1] ? s_dat_i : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed, table-driven bench for wb_arbiter (watchdog limit 4) plus a
// hand-written asynchronous-reset sequence.
module tb_wb_arbiter;

    localparam int AW = 2;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i, m0_dat_o;
    logic          m0_ack_o, m0_err_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i, m1_dat_o;
    logic          m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o, s_dat_i;
    logic          s_ack_i;
    logic [1:0]    gnt_o;

    always #5 clk_i = ~clk_i;

    wb_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    typedef struct packed {
        logic          cyc, stb, we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } m_in_t;

    typedef struct packed {
        logic [1:0]    gnt;
        logic          cyc, stb, we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } s_exp_t;

    typedef struct packed {
        logic          ack, err;
        logic [DW-1:0] dat;
    } m_exp_t;

    typedef struct packed {
        m_in_t         m0, m1;
        logic          ack;
        logic [DW-1:0] sdat;
        s_exp_t        s;
        m_exp_t        e0, e1;
    } vec_t;

    int checks = 0;
    int passes = 0;
    vec_t vq[$];

    function automatic m_in_t mi(input logic c, input logic s, input logic w,
                                 input logic [AW-1:0] a, input logic [DW-1:0] d);
        return '{c, s, w, a, d};
    endfunction

    function automatic s_exp_t se(input logic [1:0] g, input logic c, input logic s,
                                  input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        return '{g, c, s, w, a, d};
    endfunction

    function automatic m_exp_t me(input logic a, input logic e, input logic [DW-1:0] d);
        return '{a, e, d};
    endfunction

    function automatic vec_t vec(input m_in_t a, input m_in_t b, input logic k,
                                 input logic [DW-1:0] sd, input s_exp_t s,
                                 input m_exp_t e0, input m_exp_t e1);
        return '{a, b, k, sd, s, e0, e1};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        m0_cyc_i = v.m0.cyc; m0_stb_i = v.m0.stb; m0_we_i = v.m0.we;
        m0_adr_i = v.m0.adr; m0_dat_i = v.m0.dat;
        m1_cyc_i = v.m1.cyc; m1_stb_i = v.m1.stb; m1_we_i = v.m1.we;
        m1_adr_i = v.m1.adr; m1_dat_i = v.m1.dat;
        s_ack_i  = v.ack;    s_dat_i  = v.sdat;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d gnt_o", i),    32'(gnt_o),    32'(v.s.gnt));
        chk($sformatf("v%0d s_cyc_o", i),  32'(s_cyc_o),  32'(v.s.cyc));
        chk($sformatf("v%0d s_stb_o", i),  32'(s_stb_o),  32'(v.s.stb));
        chk($sformatf("v%0d s_we_o", i),   32'(s_we_o),   32'(v.s.we));
        chk($sformatf("v%0d s_adr_o", i),  32'(s_adr_o),  32'(v.s.adr));
        chk($sformatf("v%0d s_dat_o", i),  32'(s_dat_o),  32'(v.s.dat));
        chk($sformatf("v%0d m0_ack_o", i), 32'(m0_ack_o), 32'(v.e0.ack));
        chk($sformatf("v%0d m0_err_o", i), 32'(m0_err_o), 32'(v.e0.err));
        chk($sformatf("v%0d m0_dat_o", i), 32'(m0_dat_o), 32'(v.e0.dat));
        chk($sformatf("v%0d m1_ack_o", i), 32'(m1_ack_o), 32'(v.e1.ack));
        chk($sformatf("v%0d m1_err_o", i), 32'(m1_err_o), 32'(v.e1.err));
        chk($sformatf("v%0d m1_dat_o", i), 32'(m1_dat_o), 32'(v.e1.dat));
    endtask

    initial begin
        m_in_t  idle_m;
        s_exp_t zs;
        m_exp_t ze;
        m_in_t  m0c, m1c, m0w, m0h, m0t, m0a;

        idle_m = mi(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        zs     = se(2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        ze     = me(1'b0, 1'b0, 8'h00);
        m0c    = mi(1'b1, 1'b1, 1'b1, 2'd1, 8'h10);
        m1c    = mi(1'b1, 1'b1, 1'b0, 2'd3, 8'h20);
        m0w    = mi(1'b1, 1'b1, 1'b1, 2'd2, 8'h5A);
        m0h    = mi(1'b1, 1'b1, 1'b0, 2'd1, 8'h00);
        m0t    = mi(1'b1, 1'b1, 1'b0, 2'd1, 8'h00);
        m0a    = mi(1'b1, 1'b1, 1'b1, 2'd0, 8'h42);

        // Reset state, with slave data present but not routed.
        vq.push_back(vec(idle_m, idle_m, 1'b0, 8'hA5, zs, ze, ze));
        // Contention from reset: m0 first, ack on the drop cycle, direct handover.
        vq.push_back(vec(m0c, m1c, 1'b0, 8'hA5, zs, ze, ze));
        vq.push_back(vec(m0c, m1c, 1'b1, 8'h77, se(2'b01, 1'b1, 1'b1, 1'b1, 2'd1, 8'h10), me(1'b1, 1'b0, 8'h77), ze));
        vq.push_back(vec(idle_m, m1c, 1'b1, 8'h77, se(2'b01, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00), me(1'b1, 1'b0, 8'h77), ze));
        vq.push_back(vec(idle_m, m1c, 1'b1, 8'h3C, se(2'b10, 1'b1, 1'b1, 1'b0, 2'd3, 8'h20), ze, me(1'b1, 1'b0, 8'h3C)));
        vq.push_back(vec(idle_m, idle_m, 1'b0, 8'h3C, se(2'b10, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00), ze, me(1'b0, 1'b0, 8'h3C)));
        vq.push_back(vec(idle_m, idle_m, 1'b0, 8'h3C, zs, ze, ze));
        // Single master write, ack two cycles after the first granted strobe.
        vq.push_back(vec(m0w, idle_m, 1'b0, 8'hC3, zs, ze, ze));
        vq.push_back(vec(m0w, idle_m, 1'b0, 8'hC3, se(2'b01, 1'b1, 1'b1, 1'b1, 2'd2, 8'h5A), me(1'b0, 1'b0, 8'hC3), ze));
        vq.push_back(vec(m0w, idle_m, 1'b0, 8'hC3, se(2'b01, 1'b1, 1'b1, 1'b1, 2'd2, 8'h5A), me(1'b0, 1'b0, 8'hC3), ze));
        vq.push_back(vec(m0w, idle_m, 1'b1, 8'hC3, se(2'b01, 1'b1, 1'b1, 1'b1, 2'd2, 8'h5A), me(1'b1, 1'b0, 8'hC3), ze));
        vq.push_back(vec(idle_m, idle_m, 1'b0, 8'hC3, se(2'b01, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00), me(1'b0, 1'b0, 8'hC3), ze));
        vq.push_back(vec(idle_m, idle_m, 1'b0, 8'hC3, zs, ze, ze));
        // Tie after m0 was last owner: m1 first; then a 3-read burst while m0 waits.
        vq.push_back(vec(m0h, mi(1'b1, 1'b1, 1'b0, 2'd2, 8'h00), 1'b0, 8'h00, zs, ze, ze));
        vq.push_back(vec(m0h, mi(1'b1, 1'b1, 1'b0, 2'd1, 8'h00), 1'b1, 8'h11, se(2'b10, 1'b1, 1'b1, 1'b0, 2'd1, 8'h00), ze, me(1'b1, 1'b0, 8'h11)));
        vq.push_back(vec(m0h, mi(1'b1, 1'b0, 1'b0, 2'd1, 8'h00), 1'b0, 8'h00, se(2'b10, 1'b1, 1'b0, 1'b0, 2'd1, 8'h00), ze, me(1'b0, 1'b0, 8'h00)));
        vq.push_back(vec(m0h, mi(1'b1, 1'b1, 1'b0, 2'd2, 8'h00), 1'b1, 8'h22, se(2'b10, 1'b1, 1'b1, 1'b0, 2'd2, 8'h00), ze, me(1'b1, 1'b0, 8'h22)));
        vq.push_back(vec(m0h, mi(1'b1, 1'b0, 1'b0, 2'd2, 8'h00), 1'b0, 8'h00, se(2'b10, 1'b1, 1'b0, 1'b0, 2'd2, 8'h00), ze, me(1'b0, 1'b0, 8'h00)));
        vq.push_back(vec(m0h, mi(1'b1, 1'b1, 1'b0, 2'd3, 8'h00), 1'b1, 8'h33, se(2'b10, 1'b1, 1'b1, 1'b0, 2'd3, 8'h00), ze, me(1'b1, 1'b0, 8'h33)));
        vq.push_back(vec(m0h, idle_m, 1'b0, 8'h00, se(2'b10, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00), ze, ze));
        // m0 now owns; slave never acks: err and masked strobe on the 5th strobe cycle.
        for (int k = 0; k < 4; k++) begin
            vq.push_back(vec(m0t, idle_m, 1'b0, 8'h99, se(2'b01, 1'b1, 1'b1, 1'b0, 2'd1, 8'h00), me(1'b0, 1'b0, 8'h99), ze));
        end
        vq.push_back(vec(m0t, idle_m, 1'b0, 8'h99, se(2'b01, 1'b1, 1'b0, 1'b0, 2'd1, 8'h00), me(1'b0, 1'b1, 8'h99), ze));
        vq.push_back(vec(idle_m, idle_m, 1'b0, 8'h99, se(2'b01, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00), me(1'b0, 1'b0, 8'h99), ze));
        vq.push_back(vec(idle_m, idle_m, 1'b0, 8'h99, zs, ze, ze));
        // Ack exactly on the threshold cycle wins over the timeout.
        vq.push_back(vec(m0a, idle_m, 1'b0, 8'h00, zs, ze, ze));
        for (int k = 0; k < 4; k++) begin
            vq.push_back(vec(m0a, idle_m, 1'b0, 8'h00, se(2'b01, 1'b1, 1'b1, 1'b1, 2'd0, 8'h42), ze, ze));
        end
        vq.push_back(vec(m0a, idle_m, 1'b1, 8'h6E, se(2'b01, 1'b1, 1'b1, 1'b1, 2'd0, 8'h42), me(1'b1, 1'b0, 8'h6E), ze));
        vq.push_back(vec(idle_m, idle_m, 1'b0, 8'h00, se(2'b01, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00), ze, ze));
        vq.push_back(vec(idle_m, idle_m, 1'b0, 8'h00, zs, ze, ze));

        drive(vec(idle_m, idle_m, 1'b0, 8'h00, zs, ze, ze));
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk_i);
            #1 drive(vq[i]);
            @(negedge clk_i);
            check_vec(i, vq[i]);
        end

        // Asynchronous reset pulse while m1 is mid-read.
        @(posedge clk_i);
        #1 drive(vec(idle_m, mi(1'b1, 1'b1, 1'b0, 2'd2, 8'h00), 1'b0, 8'h00, zs, ze, ze));
        @(posedge clk_i);
        #1 s_ack_i = 1'b1;
        s_dat_i = 8'h55;
        @(negedge clk_i);
        chk("rst pre gnt_o", 32'(gnt_o), 32'h2);
        chk("rst pre m1_dat_o", 32'(m1_dat_o), 32'h55);
        #1 rst_i = 1'b1;
        #1;
        chk("rst async gnt_o", 32'(gnt_o), 32'h0);
        chk("rst async s_cyc_o", 32'(s_cyc_o), 32'h0);
        chk("rst async s_stb_o", 32'(s_stb_o), 32'h0);
        chk("rst async m1_ack_o", 32'(m1_ack_o), 32'h0);
        chk("rst async m1_dat_o", 32'(m1_dat_o), 32'h0);
        chk("rst async m1_err_o", 32'(m1_err_o), 32'h0);
        drive(vec(m0t, mi(1'b1, 1'b1, 1'b0, 2'd3, 8'h00), 1'b0, 8'h00, zs, ze, ze));
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("post rst tie gnt_o", 32'(gnt_o), 32'h1);
        chk("post rst tie s_adr_o", 32'(s_adr_o), 32'h1);
        @(posedge clk_i);
        #1 drive(vec(idle_m, idle_m, 1'b0, 8'h00, zs, ze, ze));
        @(posedge clk_i);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
